// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Program-counter and fetch-control stage in front of a zero-wait-state
//   instruction ROM. It runs the Start/Done handshake with the testbench and
//   sequences the PC through four actions: increment, stall, branch through an
//   internal target LUT, and halt.
//
// Parameters
//   D      PC width (matches the ROM address width)
//   LUT_W  branch-target LUT index width (2**LUT_W entries of D bits)
//   HALT   instruction encoding that ends the program
//
// Ports
//   Clk       in   clock, rising-edge active
//   Reset     in   asynchronous, active-high reset
//   Start     in   high arms and holds PC at 0; its falling edge launches RUN
//   InstIn    in   instruction returned by the ROM for the current PrgCtr
//   Stall     in   hold the PC this cycle
//   BranchEn  in   branch this cycle to LUT[TargIdx]
//   TargIdx   in   branch-target LUT index
//   LutWe     in   LUT write enable (honoured in every state)
//   LutAddr   in   LUT write index
//   LutData   in   LUT write data (absolute target address)
//   PrgCtr    out  registered program counter to the ROM
//   Running   out  registered decode of state RUN
//   Done      out  registered decode of state DONE
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int         D     = 12,
   parameter int         LUT_W = 4,
   parameter logic [8:0] HALT  = 9'h1FF
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [8:0]       InstIn,
   input  logic             Stall,
   input  logic             BranchEn,
   input  logic [LUT_W-1:0] TargIdx,
   input  logic             LutWe,
   input  logic [LUT_W-1:0] LutAddr,
   input  logic [D-1:0]     LutData,
   output logic [D-1:0]     PrgCtr,
   output logic             Running,
   output logic             Done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [D-1:0]     pc_d;
   logic             start_q;
   logic             start_fall;
   logic [D-1:0]     lut [2**LUT_W];

   assign start_fall = start_q & ~Start;

   // State, PC and the status flags. Running/Done are decoded from the next
   // state and registered, so neither output has a combinational input path.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         PrgCtr  <= '0;
         Running <= 1'b0;
         Done    <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         PrgCtr  <= pc_d;
         Running <= (state_d == RUN);
         Done    <= (state_d == DONE);
         start_q <= Start;
      end
   end

   // Branch-target table. The branch path below reads the current contents,
   // so a same-cycle write to the entry being branched through is not seen
   // until the following cycle (read-before-write).
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 2**LUT_W; i++) begin
            lut[i] <= '0;
         end
      end else if (LutWe) begin
         lut[LutAddr] <= LutData;
      end
   end

   // Next-state / next-PC. Inside RUN the branches are ordered by priority:
   // restart, halt, stall, branch, increment. HALT wins over Stall and
   // BranchEn so the program always stops on the halt word.
   always_comb begin
      state_d = state_q;
      pc_d    = PrgCtr;
      case (state_q)
         IDLE: begin
            pc_d = '0;
            if (start_fall) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (Start) begin
               state_d = IDLE;
               pc_d    = '0;
            end else if (InstIn == HALT) begin
               state_d = DONE;
            end else if (Stall) begin
               pc_d = PrgCtr;
            end else if (BranchEn) begin
               pc_d = lut[TargIdx];
            end else begin
               pc_d = PrgCtr + D'(1);
            end
         end
         DONE: begin
            if (Start) begin
               state_d = IDLE;
               pc_d    = '0;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A ROM array in the bench answers the
//   DUT's PrgCtr combinationally. A behavioural model (mode number, integer PC,
//   integer LUT) follows the fetch rules one clock at a time and every output
//   is compared after each edge. Directed scenarios come first, then a long
//   randomized run.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int         D      = 12;
   localparam int         LUT_W  = 4;
   localparam logic [8:0] HALT   = 9'h1FF;
   localparam int         PC_MOD = 1 << D;

   logic             Clk;
   logic             Reset;
   logic             Start;
   logic [8:0]       InstIn;
   logic             Stall;
   logic             BranchEn;
   logic [LUT_W-1:0] TargIdx;
   logic             LutWe;
   logic [LUT_W-1:0] LutAddr;
   logic [D-1:0]     LutData;
   logic [D-1:0]     PrgCtr;
   logic             Running;
   logic             Done;

   logic [8:0]       rom [PC_MOD];

   // model state: mode 0 = idle, 1 = run, 2 = done
   int               m_mode;
   int               m_pc;
   bit               m_startq;
   int               m_lut [2**LUT_W];

   int               n_checks;
   int               n_fail;

   fetch_unit #(.D(D), .LUT_W(LUT_W), .HALT(HALT)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .InstIn   (InstIn),
      .Stall    (Stall),
      .BranchEn (BranchEn),
      .TargIdx  (TargIdx),
      .LutWe    (LutWe),
      .LutAddr  (LutAddr),
      .LutData  (LutData),
      .PrgCtr   (PrgCtr),
      .Running  (Running),
      .Done     (Done)
   );

   assign InstIn = rom[PrgCtr];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_pc     = 0;
      m_startq = 0;
      for (int i = 0; i < 2**LUT_W; i++) m_lut[i] = 0;
   endtask

   // One clock of the fetch rules, using the inputs currently driven.
   task automatic model_step();
      int ins;
      int tgt;
      bit fell;
      ins  = rom[m_pc];
      tgt  = m_lut[TargIdx];
      fell = m_startq && !Start;
      case (m_mode)
         0: begin
            m_pc = 0;
            if (fell) m_mode = 1;
         end
         1: begin
            if (Start) begin
               m_mode = 0;
               m_pc   = 0;
            end else if (ins == HALT) begin
               m_mode = 2;
            end else if (!Stall) begin
               if (BranchEn) m_pc = tgt;
               else          m_pc = (m_pc + 1) % PC_MOD;
            end
         end
         default: begin
            if (Start) begin
               m_mode = 0;
               m_pc   = 0;
            end
         end
      endcase
      if (LutWe) m_lut[LutAddr] = LutData;
      m_startq = Start;
   endtask

   // Advance one clock and compare all outputs against the model.
   task automatic cycle();
      model_step();
      @(posedge Clk);
      #1;
      check("pc", PrgCtr, m_pc);
      check("running", Running, (m_mode == 1));
      check("done", Done, (m_mode == 2));
   endtask

   task automatic quiet();
      Stall    = 1'b0;
      BranchEn = 1'b0;
      LutWe    = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      Reset    = 1'b0;
      Start    = 1'b0;
      Stall    = 1'b0;
      BranchEn = 1'b0;
      TargIdx  = '0;
      LutWe    = 1'b0;
      LutAddr  = '0;
      LutData  = '0;
      for (int i = 0; i < PC_MOD; i++) rom[i] = 9'($urandom_range(0, 510));
      model_reset();

      #1 Reset = 1'b1;
      #11;
      check("rst_pc", PrgCtr, 0);
      check("rst_running", Running, 0);
      check("rst_done", Done, 0);
      Reset = 1'b0;

      // Launch, with LUT[3] = 0x100 written while idle.
      Start = 1'b1; LutWe = 1'b1; LutAddr = 4'd3; LutData = 12'h100;
      cycle();
      LutWe = 1'b0;
      cycle();
      cycle();
      Start = 1'b0;
      cycle();
      check("launch_running", Running, 1);
      check("launch_pc0", PrgCtr, 0);
      for (int k = 1; k <= 5; k++) begin
         cycle();
         check("launch_inc", PrgCtr, k);
      end

      // Branch at PC 5 with a simultaneous write to the same entry.
      BranchEn = 1'b1; TargIdx = 4'd3;
      LutWe = 1'b1; LutAddr = 4'd3; LutData = 12'h200;
      cycle();
      check("br_old_val", PrgCtr, 12'h100);
      quiet();
      cycle();
      check("br_next", PrgCtr, 12'h101);
      BranchEn = 1'b1;
      cycle();
      check("br_new_val", PrgCtr, 12'h200);
      quiet();

      // Stall at PC 10 with BranchEn also high.
      LutWe = 1'b1; LutAddr = 4'd5; LutData = 12'd10;
      cycle();
      quiet();
      BranchEn = 1'b1; TargIdx = 4'd5;
      cycle();
      check("to_10", PrgCtr, 10);
      Stall = 1'b1; TargIdx = 4'd3;
      repeat (3) begin
         cycle();
         check("stall_hold", PrgCtr, 10);
      end
      quiet();
      cycle();
      check("stall_release", PrgCtr, 11);

      // Wrap-around from 0xFFF.
      LutWe = 1'b1; LutAddr = 4'd0; LutData = 12'hFFF;
      cycle();
      quiet();
      BranchEn = 1'b1; TargIdx = 4'd0;
      cycle();
      check("wrap_fff", PrgCtr, 12'hFFF);
      quiet();
      cycle();
      check("wrap_000", PrgCtr, 0);

      // Halt at word 7 with Stall and BranchEn high on that cycle.
      rom[7] = HALT;
      repeat (7) cycle();
      check("halt_addr", PrgCtr, 7);
      Stall = 1'b1; BranchEn = 1'b1;
      cycle();
      check("halt_done", Done, 1);
      check("halt_running", Running, 0);
      repeat (5) begin
         Stall = 1'($urandom_range(0, 1)); BranchEn = 1'($urandom_range(0, 1));
         cycle();
         check("halt_hold", PrgCtr, 7);
      end
      quiet();
      Start = 1'b1;
      cycle();
      check("restart_done", Done, 0);
      check("restart_pc", PrgCtr, 0);
      rom[7] = 9'($urandom_range(0, 510));
      Start = 1'b0;
      cycle();
      check("relaunch", Running, 1);

      // Async reset at PC 37, between edges.
      LutWe = 1'b1; LutAddr = 4'd9; LutData = 12'd37;
      cycle();
      quiet();
      BranchEn = 1'b1; TargIdx = 4'd9;
      cycle();
      check("at_37", PrgCtr, 37);
      quiet();
      #2 Reset = 1'b1;
      #1;
      check("arst_pc", PrgCtr, 0);
      check("arst_running", Running, 0);
      check("arst_done", Done, 0);
      model_reset();
      #1 Reset = 1'b0;
      Start = 1'b1;
      cycle();
      Start = 1'b0;
      cycle();
      BranchEn = 1'b1; TargIdx = 4'd9;
      cycle();
      check("lut_cleared", PrgCtr, 0);
      quiet();

      // Randomized run with sparse halt words.
      for (int i = 0; i < PC_MOD; i++)
         rom[i] = ($urandom_range(0, 47) == 0) ? HALT : 9'($urandom_range(0, 510));
      for (int n = 0; n < 4000; n++) begin
         Start    = ($urandom_range(0, 29) == 0);
         Stall    = ($urandom_range(0, 3) == 0);
         BranchEn = ($urandom_range(0, 3) == 0);
         TargIdx  = LUT_W'($urandom_range(0, 2**LUT_W - 1));
         LutWe    = ($urandom_range(0, 3) == 0);
         LutAddr  = LUT_W'($urandom_range(0, 2**LUT_W - 1));
         LutData  = D'($urandom_range(0, PC_MOD - 1));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-control stage that drives the address port of the instruction ROM and watches the 9-bit instruction it returns. It implements the Start/Done handshake with the testbench and sequences the PC (increment, stall, branch through an internal target lookup table, halt). The PC feeds the combinational ROM read, so the addressed instruction is valid in the same cycle.

## Interface
- D, 12: PC width. Must match the ROM address width.
- LUT_W, 4: branch-target LUT index width; the LUT has 2**LUT_W entries of D bits.
- HALT, 9'h1FF: instruction encoding that ends the program.

- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  testbench request; high arms and holds PC at 0, falling edge launches execution.
- InstIn  in  9  instruction returned by the ROM for the current PrgCtr.
- Stall  in  1  hold the PC this cycle. Driven by the downstream datapath.
- BranchEn  in  1  take the branch this cycle, to LUT[TargIdx].
- TargIdx  in  LUT_W  branch-target LUT index.
- LutWe  in  1  LUT write enable.
- LutAddr  in  LUT_W  LUT write index.
- LutData  in  D  LUT write data (absolute target address).
- PrgCtr  out  D  registered program counter to the ROM.
- Running  out  1  high while in RUN.
- Done  out  1  high while in DONE.

## Operation
- Reset (asynchronous) forces the following, effective immediately:
  - State = IDLE, PrgCtr = 0, Done = 0, Running = 0.
  - Start_q = 0.
  - All LUT entries = 0.
- Start_q is a registered copy of Start and is used for falling-edge detection (Start_q=1 and Start=0).
- States: IDLE, RUN, DONE.
- IDLE:
  - PrgCtr holds 0.
  - On a Start falling edge, go to RUN with PrgCtr = 0, so instruction 0 executes first.
- RUN, evaluated in priority order each cycle:
  1. Start=1: go to IDLE, PrgCtr = 0.
  2. InstIn == HALT: go to DONE, PrgCtr holds. This applies even if Stall or BranchEn is also high.
  3. Stall=1: PrgCtr holds. BranchEn is ignored.
  4. BranchEn=1: PrgCtr = LUT[TargIdx].
  5. Otherwise: PrgCtr = PrgCtr + 1, modulo 2**D, so 2**D-1 wraps to 0.
- DONE:
  - PrgCtr holds.
  - Stall, BranchEn and InstIn are ignored.
  - Start=1: go to IDLE, PrgCtr = 0.
- Done = (state == DONE). Running = (state == RUN). Both are registered state decodes, so there are no combinational paths from inputs.
- LUT write:
  - Occurs at the clock edge whenever LutWe=1, in any state.
  - A branch reading the entry being written in the same cycle gets the old value (read-before-write).

## Timing
- PrgCtr changes only on the rising Clk edge, or asynchronously on Reset.
- InstIn is sampled in the same cycle PrgCtr presents its address. This is a zero-wait-state ROM.
- Branch latency: BranchEn sampled at edge N puts the target on PrgCtr after edge N; the target instruction is fetched in cycle N+1.
- Start high for any number of cycles, then low: RUN begins at the first edge where Start=0 and Start_q=1. The PC stays 0 for that cycle, then increments.
- Halt: HALT seen on InstIn at edge N gives Done=1 and Running=0 after edge N, with PrgCtr still at the halt address.
- Start in DONE: Done drops and PrgCtr=0 after the next edge. A further falling edge of Start is required to run again.
- Reset asserted mid-RUN or mid-DONE: outputs clear without waiting for Clk. After Reset deasserts, a fresh Start pulse is required.

## Test plan
- Reset and launch:
  - Stimulus: Reset pulse, Start=1 for 3 cycles, then 0; ROM holds no HALT.
  - Required: PrgCtr=0 through the first RUN cycle, then 1, 2, 3; Running=1 and Done=0 during RUN.
- Branch via LUT:
  - Stimulus: write LUT[3]=12'h100 in IDLE; in RUN at PrgCtr=5, BranchEn=1 with TargIdx=3.
  - Required: next PrgCtr=12'h100, then 12'h101.
  - Also: LutWe to index 3 with data 12'h200 in the same cycle as the branch gives 12'h100; a later branch to index 3 gives 12'h200.
- Stall:
  - Stimulus: at PrgCtr=10, Stall=1 for 3 cycles with BranchEn=1 and TargIdx=3.
  - Required: PrgCtr stays 10 for 3 cycles, then 11 when Stall drops and BranchEn=0.
- Halt and restart:
  - Stimulus: ROM word 7 = 9'h1FF, with Stall=1 on that cycle.
  - Required: Done=1 and Running=0 one edge later, PrgCtr stays 7 indefinitely. Then Start=1 gives Done=0 and PrgCtr=0 next cycle.
- Wrap-around:
  - Stimulus: LUT[0]=12'hFFF; branch with TargIdx=0.
  - Required: PrgCtr=12'hFFF, then 12'h000 on the next increment.
- Asynchronous reset:
  - Stimulus: RUN with PrgCtr=37, Reset asserted between clock edges.
  - Required: PrgCtr=0, Running=0 and Done=0 before the next edge; LUT reads return 0 afterwards.
